// File: rtl/i2c_master.sv
// Single-master I2C engine: one register write or read transaction per request.
// Define I2C_NACK_ABORT_EN to jump straight to STOP on any slave NACK.
module i2c_master #(
    parameter int QTR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        scl,
    input  logic [6:0]  ext_slave_address_in,
    input  logic        ext_read_write_in,
    input  logic [7:0]  ext_register_address_in,
    input  logic [31:0] ext_data_in,
    output logic        sda_out,
    input  logic        sda_in,
    output logic [31:0] ext_data_out,
    output logic        busy,
    output logic        done,
    output logic        nack
);
    localparam int DW = (QTR > 2) ? $clog2(QTR) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(QTR - 1);

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_START      = 4'd1;
    localparam logic [3:0] S_ADDR       = 4'd2;
    localparam logic [3:0] S_ACK_ADDR   = 4'd3;
    localparam logic [3:0] S_REG        = 4'd4;
    localparam logic [3:0] S_ACK_REG    = 4'd5;
    localparam logic [3:0] S_WDATA      = 4'd6;
    localparam logic [3:0] S_ACK_W      = 4'd7;
    localparam logic [3:0] S_RSTART     = 4'd8;
    localparam logic [3:0] S_ADDR_R     = 4'd9;
    localparam logic [3:0] S_ACK_ADDR_R = 4'd10;
    localparam logic [3:0] S_RDATA      = 4'd11;
    localparam logic [3:0] S_MACK       = 4'd12;
    localparam logic [3:0] S_STOP       = 4'd13;

    logic [3:0]    state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [6:0]    addr_q, addr_d;
    logic          rw_q, rw_d;
    logic [7:0]    reg_q, reg_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [31:0]   rx_q, rx_d;
    logic [31:0]   dout_q, dout_d;
    logic          done_q, done_d;
    logic          nack_q, nack_d;

    logic       tick, slot_end, last_bit, ack_slot, bit_slot;
    logic [7:0] tx_byte;
    logic       tx_bit;

    assign tick     = div_q == DIV_MAX;
    assign slot_end = tick && (qtr_q == 2'd3);
    assign last_bit = bit_q == 3'd7;
    assign ack_slot = state_q inside {S_ACK_ADDR, S_ACK_REG, S_ACK_W, S_ACK_ADDR_R};
    assign bit_slot = state_q inside {S_ADDR, S_REG, S_WDATA, S_ADDR_R, S_RDATA};

    always_comb begin
        tx_byte = 8'hFF;
        unique case (state_q)
            S_ADDR:   tx_byte = {addr_q, 1'b0};
            S_ADDR_R: tx_byte = {addr_q, 1'b1};
            S_REG:    tx_byte = reg_q;
            S_WDATA: begin
                unique case (byte_q)
                    2'd0:    tx_byte = wdat_q[31:24];
                    2'd1:    tx_byte = wdat_q[23:16];
                    2'd2:    tx_byte = wdat_q[15:8];
                    default: tx_byte = wdat_q[7:0];
                endcase
            end
            default: ;
        endcase
        tx_bit = tx_byte[3'd7 - bit_q];
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        reg_d   = reg_q;
        wdat_d  = wdat_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        nack_d  = nack_q;
        if (state_q == S_IDLE) begin
            div_d  = '0;
            qtr_d  = 2'd0;
            bit_d  = 3'd0;
            byte_d = 2'd0;
            if (en) begin
                state_d = S_START;
                addr_d  = ext_slave_address_in;
                rw_d    = ext_read_write_in;
                reg_d   = ext_register_address_in;
                wdat_d  = ext_data_in;
                nack_d  = 1'b0;
            end
        end else begin
            div_d = tick ? '0 : div_q + DW'(1);
            if (tick) qtr_d = qtr_q + 2'd1;
        end
        if (slot_end) begin
            // bit counter wraps 7 -> 0 on its own as each byte ends
            if (bit_slot) bit_d = bit_q + 3'd1;
            unique case (state_q)
                S_START:      state_d = S_ADDR;
                S_ADDR:       if (last_bit) state_d = S_ACK_ADDR;
                S_ACK_ADDR:   state_d = S_REG;
                S_REG:        if (last_bit) state_d = S_ACK_REG;
                S_ACK_REG:    state_d = rw_q ? S_RSTART : S_WDATA;
                S_WDATA:      if (last_bit) state_d = S_ACK_W;
                S_ACK_W: begin
                    byte_d  = byte_q + 2'd1;
                    state_d = (byte_q == 2'd3) ? S_STOP : S_WDATA;
                end
                S_RSTART:     state_d = S_ADDR_R;
                S_ADDR_R:     if (last_bit) state_d = S_ACK_ADDR_R;
                S_ACK_ADDR_R: state_d = S_RDATA;
                S_RDATA: begin
                    rx_d = {rx_q[30:0], sda_in};
                    if (last_bit) state_d = S_MACK;
                end
                S_MACK: begin
                    byte_d = byte_q + 2'd1;
                    if (byte_q == 2'd3) begin
                        state_d = S_STOP;
                        dout_d  = rx_q;
                    end else begin
                        state_d = S_RDATA;
                    end
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (ack_slot && sda_in) begin
                nack_d = 1'b1;
`ifdef I2C_NACK_ABORT_EN
                state_d = S_STOP;
`endif
            end
        end
    end

    always_comb begin
        scl     = 1'b1;
        sda_out = 1'b1;
        unique case (state_q)
            S_IDLE:  ;
            S_START: sda_out = ~qtr_q[1];
            S_RSTART: begin
                scl     = qtr_q != 2'd0;
                sda_out = ~qtr_q[1];
            end
            S_STOP: begin
                scl     = qtr_q[1];
                sda_out = qtr_q == 2'd3;
            end
            S_MACK: begin
                scl     = qtr_q[1];
                sda_out = byte_q == 2'd3;
            end
            default: begin
                scl     = qtr_q[1];
                sda_out = tx_bit;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            addr_q  <= 7'd0;
            rw_q    <= 1'b0;
            reg_q   <= 8'd0;
            wdat_q  <= 32'd0;
            rx_q    <= 32'd0;
            dout_q  <= 32'd0;
            done_q  <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            reg_q   <= reg_d;
            wdat_q  <= wdat_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            nack_q  <= nack_d;
        end
    end

    assign ext_data_out = dout_q;
    assign busy         = state_q != S_IDLE;
    assign done         = done_q;
    assign nack         = nack_q;
endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: bus monitor plus slave model, vector table,
// and hand sequences for reset mid-transfer and requests while busy.
module tb_i2c_master;
    localparam int QTR  = 4;
    localparam int SLOT = 4 * QTR;
    localparam int EV_S = 1000;
    localparam int EV_P = 2000;
`ifdef I2C_NACK_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        scl, sda_out, sda_in;
    logic [6:0]  addr_i = 7'd0;
    logic        rw_i = 1'b0;
    logic [7:0]  reg_i = 8'd0;
    logic [31:0] wd_i = 32'd0;
    logic [31:0] dout;
    logic        busy, done, nack;

    always #5 clk = ~clk;

    i2c_master #(.QTR(QTR)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .scl(scl),
        .ext_slave_address_in(addr_i),
        .ext_read_write_in(rw_i),
        .ext_register_address_in(reg_i),
        .ext_data_in(wd_i),
        .sda_out(sda_out),
        .sda_in(sda_in),
        .ext_data_out(dout),
        .busy(busy),
        .done(done),
        .nack(nack)
    );

    // open-drain bus: master and slave model both pull low
    logic slv = 1'b1;
    assign sda_in = sda_out & slv;

    logic        pscl = 1'b1, psda = 1'b1, rdm = 1'b0;
    int          bitn = 0, frame = 0;
    logic [7:0]  sh = 8'd0;
    int          ev[$];
    int          busy_cnt = 0, done_cnt = 0;
    logic        nk_mode = 1'b0;
    logic [31:0] rsrc = 32'd0;

    function automatic logic slave_bit(int b, int f, logic r);
        if (r && f >= 1 && f <= 4) begin
            if (b < 8) return rsrc[31 - 8 * (f - 1) - b];
            return 1'b1;
        end
        if (b == 8) return nk_mode;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        pscl <= scl;
        psda <= sda_in;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (rst) begin
            bitn <= 0; frame <= 0; rdm <= 1'b0; slv <= 1'b1;
        end else if (pscl && scl && psda && !sda_in) begin
            ev.push_back(EV_S);
            bitn <= 0; frame <= 0; rdm <= 1'b0; slv <= 1'b1;
        end else if (pscl && scl && !psda && sda_in) begin
            ev.push_back(EV_P);
            bitn <= 0; slv <= 1'b1;
        end else if (!pscl && scl) begin
            sh <= {sh[6:0], sda_in};
            if (bitn == 8) begin
                ev.push_back(int'({sda_in, sh}));
                bitn <= 0;
                frame <= frame + 1;
                if (frame == 0) rdm <= sh[0];
            end else begin
                bitn <= bitn + 1;
            end
        end else if (pscl && !scl) begin
            slv <= slave_bit(bitn, frame, rdm);
        end
    end

    int n_chk = 0, n_pass = 0;
    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    int expq[$];
    task automatic build_exp(logic rw, logic [6:0] a, logic [7:0] r,
                             logic [31:0] wd, logic [31:0] rd, logic nk);
        int ak;
        ak = nk ? 256 : 0;
        expq.delete();
        expq.push_back(EV_S);
        expq.push_back(ak + int'({a, 1'b0}));
        if (ABORT && nk) begin
            expq.push_back(EV_P);
            return;
        end
        expq.push_back(ak + int'(r));
        if (!rw) begin
            for (int k = 0; k < 4; k++) expq.push_back(ak + int'(wd[31 - 8 * k -: 8]));
        end else begin
            expq.push_back(EV_S);
            expq.push_back(ak + int'({a, 1'b1}));
            for (int k = 0; k < 4; k++)
                expq.push_back((k == 3 ? 256 : 0) + int'(rd[31 - 8 * k -: 8]));
        end
        expq.push_back(EV_P);
    endtask

    task automatic check_events(string tag, int base);
        chk({tag, "_evcount"}, ev.size() - base, expq.size());
        for (int i = 0; i < expq.size(); i++)
            if (base + i < ev.size())
                chk($sformatf("%s_ev%0d", tag, i), ev[base + i], expq[i]);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        rw;
        logic [6:0]  a;
        logic [7:0]  r;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        nk;
    } vec_t;

    vec_t        vt[5];
    logic [31:0] dmodel = 32'd0;

    task automatic run_vec(vec_t v, string tag);
        int base, b0, d0, slots;
        bit ok;
        base = ev.size(); b0 = busy_cnt; d0 = done_cnt;
        addr_i = v.a; rw_i = v.rw; reg_i = v.r; wd_i = v.wd;
        nk_mode = v.nk; rsrc = v.rd;
        build_exp(v.rw, v.a, v.r, v.wd, v.rd, v.nk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_done(ok);
        chk({tag, "_done_seen"}, ok, 1);
        repeat (4) @(negedge clk);
        if (ABORT && v.nk) slots = 11;
        else if (v.rw) slots = 66;
        else slots = 56;
        if (v.rw && !(ABORT && v.nk)) dmodel = v.rd;
        chk({tag, "_busy_clks"}, busy_cnt - b0, slots * SLOT);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_nack"}, nack, v.nk);
        chk({tag, "_dout"}, dout, dmodel);
        check_events(tag, base);
    endtask

    initial begin
        int bad, base;
        bit ok;
        vt[0] = '{1'b0, 7'h50, 8'h12, 32'hDEADBEEF, 32'h0, 1'b0};
        vt[1] = '{1'b1, 7'h50, 8'h34, 32'h0, 32'h01234567, 1'b0};
        vt[2] = '{1'b0, 7'h50, 8'h12, 32'hDEADBEEF, 32'h0, 1'b1};
        vt[3] = '{1'b0, 7'h2A, 8'hFF, 32'h00FF5AA5, 32'h0, 1'b0};
        vt[4] = '{1'b1, 7'h7F, 8'h00, 32'h0, 32'hFEDCBA98, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_scl", scl, 1);
        chk("rst_sda", sda_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_nack", nack, 0);
        chk("rst_dout", dout, 0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (scl !== 1'b1 || sda_out !== 1'b1 || busy !== 1'b0 || dout !== 32'd0) bad++;
        end
        chk("idle_bus", bad, 0);

        for (int i = 0; i < 5; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // requests and input changes while busy must not disturb the transfer
        base = ev.size();
        addr_i = vt[3].a; rw_i = 1'b0; reg_i = vt[3].r; wd_i = vt[3].wd;
        nk_mode = 1'b0;
        build_exp(1'b0, vt[3].a, vt[3].r, vt[3].wd, 32'h0, 1'b0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (100) @(negedge clk);
        addr_i = 7'h11; reg_i = 8'h77; wd_i = 32'h13579BDF;
        for (int k = 0; k < 5; k++) begin
            en = 1'b1;
            @(negedge clk);
            en = 1'b0;
            repeat (50) @(negedge clk);
        end
        en = 1'b1;
        wait_done(ok);
        chk("held_done_seen", ok, 1);
        chk("held_gap_busy", busy, 0);
        @(negedge clk);
        chk("held_restart_busy", busy, 1);
        en = 1'b0;
        check_events("held", base);
        base = ev.size();
        build_exp(1'b0, 7'h11, 8'h77, 32'h13579BDF, 32'h0, 1'b0);
        wait_done(ok);
        chk("second_done_seen", ok, 1);
        repeat (4) @(negedge clk);
        check_events("second", base);

        // reset in the middle of the register byte
        base = ev.size();
        addr_i = vt[0].a; rw_i = 1'b0; reg_i = vt[0].r; wd_i = vt[0].wd;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (ev.size() >= base + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midrst_reach_reg", ok, 1);
        repeat (3 * SLOT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_scl", scl, 1);
        chk("midrst_sda", sda_out, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        dmodel = 32'd0;
        repeat (2) @(negedge clk);
        run_vec(vt[0], "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
